serial_receive: RTL and testbench

//  Host->FPGA half of the miner serial link, the counterpart of the 32-bit word sender.

---
 rtl/serial_receive.sv | 158 +++++++++++++++
 tb/tb_serial_receive.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_receive.sv
// 8N1 UART receiver that packs WORD_BYTES bytes (first byte -> MSBs) into one word.
// Optional inter-byte timeout that drops a partial word: define SERIAL_RX_TIMEOUT_EN.
module serial_receive #(
  parameter int baud_rate          = 115_200,
  parameter int comm_clk_frequency = 100_000_000,
  parameter int WORD_BYTES         = 4,
  parameter int TIMEOUT_BITS       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RxD,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_valid,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int CPB  = comm_clk_frequency / baud_rate;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int BCW  = $clog2(WORD_BYTES + 1);
  localparam int WW   = 8 * WORD_BYTES;
  localparam logic [CW-1:0]  CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
  localparam logic [BCW-1:0] LAST_B  = BCW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_rs;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_byte, w_byte_nxt;
  logic            w_byte_ok, w_ferr, w_gap_expire;
  logic [WW-1:0]   r_shreg, r_word, w_assembled;
  logic [BCW-1:0]  r_byte_cnt;
  logic            r_word_valid, r_frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_byte_ok   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rs) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CPB_M1) begin
          w_cnt_nxt  = '0;
          w_byte_nxt = {r_rs, r_byte[7:1]};
          w_bit_nxt  = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == CPB_M1) begin
          w_cnt_nxt = '0;
          if (r_rs) begin
            w_byte_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (r_rs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_assembled = (r_shreg << 8) | WW'(r_byte);

  // Sync flops reset to the idle level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= 1'b1;
      r_rs         <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_byte       <= '0;
      r_shreg      <= '0;
      r_word       <= '0;
      r_byte_cnt   <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= RxD;
      r_rs         <= r_sync1;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_byte       <= w_byte_nxt;
      r_word_valid <= 1'b0;
      r_frame_err  <= w_ferr;
      if (w_ferr) begin
        r_byte_cnt <= '0;
        r_shreg    <= '0;
      end else if (w_byte_ok) begin
        if (r_byte_cnt == LAST_B) begin
          r_word       <= w_assembled;
          r_word_valid <= 1'b1;
          r_byte_cnt   <= '0;
          r_shreg      <= '0;
        end else begin
          r_shreg    <= w_assembled;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end else if (w_gap_expire) begin
        r_byte_cnt <= '0;
        r_shreg    <= '0;
      end
    end
  end

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int GAP = TIMEOUT_BITS * CPB;
  localparam int GW  = $clog2(GAP + 1);
  logic [GW-1:0] r_gap;
  logic          w_gap_run;

  // Line idle with a partial word held; a start bit (rs low) clears the count.
  assign w_gap_run    = (r_state == S_IDLE) && (r_byte_cnt != '0) && r_rs;
  assign w_gap_expire = w_gap_run && (r_gap == GW'(GAP - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                         r_gap <= '0;
    else if (w_gap_run && !w_gap_expire) r_gap <= r_gap + 1'b1;
    else                                 r_gap <= '0;
  end
`else
  assign w_gap_expire = 1'b0;
`endif

  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE) || (r_byte_cnt != '0);

endmodule

// File: tb/tb_serial_receive.sv
// Directed bench for serial_receive: CPB=16, 4-byte words, frames driven bit by bit.
module tb_serial_receive;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RxD = 1'b1;
  logic [31:0] word;
  logic        word_valid, busy, frame_err;

  int pass_cnt = 0, total = 0;
  int vcnt = 0, fcnt = 0, both = 0;
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  serial_receive #(
    .baud_rate(100_000), .comm_clk_frequency(1_600_000),
    .WORD_BYTES(4), .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD),
    .word(word), .word_valid(word_valid), .busy(busy), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (word_valid) begin
      vcnt++;
      wq.push_back(word);
    end
    if (frame_err) fcnt++;
    if (word_valid && frame_err) both++;
  end

  task automatic bit_out(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int idle);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    for (int i = 0; i < idle; i++) bit_out(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (word !== 32'h0) $display("FAIL reset_word: got %h want 00000000", word); else pass_cnt++;
    total++; if (word_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", word_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcnt;
    send_byte(8'hDE, 1'b1, 1);
    send_byte(8'hAD, 1'b1, 1);
    send_byte(8'hBE, 1'b1, 1);
    send_byte(8'hEF, 1'b1, 1);
    total++; if (word !== 32'hDEADBEEF) $display("FAIL basic_word: got %h want deadbeef", word); else pass_cnt++;
    total++; if (vcnt - v0 !== 1) $display("FAIL basic_valid_count: got %0d want 1", vcnt - v0); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL glitch_busy_high: got %b want 1", busy); else pass_cnt++;
    RxD = 1'b1;
    repeat (HALF + 3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy_low: got %b want 0", busy); else pass_cnt++;
    total++; if (fcnt - f0 !== 0) $display("FAIL glitch_ferr: got %0d want 0", fcnt - f0); else pass_cnt++;
    total++; if (vcnt - v0 !== 0) $display("FAIL glitch_valid: got %0d want 0", vcnt - v0); else pass_cnt++;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_frame_err();
    int v0, f0;
    v0 = vcnt; f0 = fcnt;
    send_byte(8'h55, 1'b1, 1);
    send_byte(8'h66, 1'b0, 1);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'h03, 1'b1, 1);
    send_byte(8'h04, 1'b1, 1);
    total++; if (fcnt - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", fcnt - f0); else pass_cnt++;
    total++; if (vcnt - v0 !== 1) $display("FAIL ferr_valid_count: got %0d want 1", vcnt - v0); else pass_cnt++;
    total++; if (word !== 32'h01020304) $display("FAIL ferr_word: got %h want 01020304", word); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int v0;
    logic [31:0] exp_w;
    logic        exp_busy;
`ifdef SERIAL_RX_TIMEOUT_EN
    exp_w = 32'h11223344; exp_busy = 1'b0;
`else
    exp_w = 32'hAABB1122; exp_busy = 1'b1;
`endif
    v0 = vcnt;
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'hBB, 1'b1, 40);
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b1, 1);
    send_byte(8'h44, 1'b1, 1);
    total++; if (word !== exp_w) $display("FAIL timeout_word: got %h want %h", word, exp_w); else pass_cnt++;
    total++; if (vcnt - v0 !== 1) $display("FAIL timeout_valid_count: got %0d want 1", vcnt - v0); else pass_cnt++;
    total++; if (busy !== exp_busy) $display("FAIL timeout_busy: got %b want %b", busy, exp_busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int v0;
    send_byte(8'h10, 1'b1, 1);
    send_byte(8'h20, 1'b1, 1);
    bit_out(1'b0);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    RxD   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (word !== 32'h0) $display("FAIL midrst_word: got %h want 00000000", word); else pass_cnt++;
    total++; if (word_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", word_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (frame_err !== 1'b0) $display("FAIL midrst_ferr: got %b want 0", frame_err); else pass_cnt++;
    repeat (2 * CPB) @(negedge clk);
    v0 = vcnt;
    send_byte(8'hCA, 1'b1, 1);
    send_byte(8'hFE, 1'b1, 1);
    send_byte(8'hBA, 1'b1, 1);
    send_byte(8'hBE, 1'b1, 1);
    total++; if (word !== 32'hCAFEBABE) $display("FAIL midrst_next_word: got %h want cafebabe", word); else pass_cnt++;
    total++; if (vcnt - v0 !== 1) $display("FAIL midrst_valid_count: got %0d want 1", vcnt - v0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    logic [7:0] bytes [8];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    v0 = vcnt; f0 = fcnt;
    wq.delete();
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 1'b1, (i == 7) ? 1 : 0);
    total++; if (vcnt - v0 !== 2) $display("FAIL b2b_valid_count: got %0d want 2", vcnt - v0); else pass_cnt++;
    total++; if (wq.size() < 1 || wq[0] !== 32'h12345678)
      $display("FAIL b2b_word0: got %h want 12345678 (captured %0d)", (wq.size() > 0) ? wq[0] : 32'hx, wq.size());
    else pass_cnt++;
    total++; if (wq.size() < 2 || wq[1] !== 32'h9ABCDEF0)
      $display("FAIL b2b_word1: got %h want 9abcdef0 (captured %0d)", (wq.size() > 1) ? wq[1] : 32'hx, wq.size());
    else pass_cnt++;
    total++; if (fcnt - f0 !== 0) $display("FAIL b2b_ferr: got %0d want 0", fcnt - f0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    total++; if (both !== 0) $display("FAIL valid_ferr_overlap: got %0d want 0", both); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
